// File: rtl/debounce_pkg.sv
// Shared helpers for the multi-channel debouncer: count derivation,
// counter sizing and parameter legality.
package debounce_pkg;

  // Number of clock cycles that make up the stability window.
  // DELAY and CLOCK_PERIOD are in the same time unit (ns).
  function automatic int count_of(longint delay, longint clock_period);
    if (clock_period <= 0) return 0;
    return int'(delay / clock_period);
  endfunction

  // Bits needed to hold 0..count inclusive.
  function automatic int cnt_width(int count);
    return $clog2(count + 1);
  endfunction

  // True when the configuration can be built.
  function automatic bit params_legal(int count, int sync_stages, int channels);
    return (count >= 1) && (sync_stages >= 2) && (channels >= 1);
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Signal bundle between switch inputs, the debouncer and its consumers.
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] signal_in;
  logic [CHANNELS-1:0] signal_out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                any_event;

  modport master (
    output signal_in,
    input  signal_out, rise, fall, any_event
  );

  modport slave (
    input  signal_in,
    output signal_out, rise, fall, any_event
  );
endinterface

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, saturating stability counter,
// registered level and single-cycle rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   COUNT       = 10,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic evt_d_o
);
  localparam int CNT_W = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Counter restarts on any synchronised change; once saturated the level is accepted.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != hist_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      if (s != out_q) begin
        out_d  = s;
        rise_d = s;
        fall_d = ~s;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser shift, history, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      hist_q <= RESET_LEVEL;
      out_q  <= RESET_LEVEL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
      hist_q <= s;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = out_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign evt_d_o = rise_d | fall_d;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: independent channels plus a shared
// registered any_event flag aligned with the per-channel pulses.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int     CHANNELS     = 4,
  parameter longint DELAY        = 10_000_000, // ns
  parameter longint CLOCK_PERIOD = 20,         // ns
  parameter int     SYNC_STAGES  = 2,
  parameter logic   RESET_LEVEL  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  debounce_multi_if.slave bus
);
  localparam int COUNT = count_of(DELAY, CLOCK_PERIOD);

  if (!params_legal(COUNT, SYNC_STAGES, CHANNELS)) begin : g_illegal
    $fatal(1, "debounce_multi: illegal parameters (COUNT=%0d SYNC_STAGES=%0d CHANNELS=%0d)",
           COUNT, SYNC_STAGES, CHANNELS);
  end

  logic [CHANNELS-1:0] evt_d;
  logic                any_event_q, any_event_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .COUNT       (COUNT),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .signal_i (bus.signal_in[i]),
      .level_o  (bus.signal_out[i]),
      .rise_o   (bus.rise[i]),
      .fall_o   (bus.fall[i]),
      .evt_d_o  (evt_d[i])
    );
  end

  // Any channel about to pulse on this edge.
  always_comb begin
    any_event_d = |evt_d;
  end

  // Register the flag so it lands on the same edge as rise/fall.
  always_ff @(posedge clk) begin
    if (rst) any_event_q <= 1'b0;
    else     any_event_q <= any_event_d;
  end

  assign bus.any_event = any_event_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with COUNT=10, two sync stages.
module tb_debounce_multi;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  debounce_multi_if #(.CHANNELS(4)) dif ();

  debounce_multi #(
    .CHANNELS     (4),
    .DELAY        (100),
    .CLOCK_PERIOD (10),
    .SYNC_STAGES  (2),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] seen;
  int         nrise0;
  int         nother;

  initial begin
    rst = 1'b1;
    dif.signal_in = 4'h0;
    tick(3);
    chk("rst_out",  32'(dif.signal_out), 32'h0);
    chk("rst_rise", 32'(dif.rise),       32'h0);
    chk("rst_fall", 32'(dif.fall),       32'h0);
    chk("rst_any",  32'(dif.any_event),  32'h0);
    rst = 1'b0;
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen |= dif.rise | dif.fall;
    end
    chk("post_rst_quiet", 32'(seen), 32'h0);

    // Clean step on ch0: accepted after the 14th edge counting the first sample.
    dif.signal_in = 4'h1;
    tick(13);
    chk("step_early_out",  32'(dif.signal_out), 32'h0);
    chk("step_early_rise", 32'(dif.rise),       32'h0);
    tick();
    chk("step_out",  32'(dif.signal_out), 32'h1);
    chk("step_rise", 32'(dif.rise),       32'h1);
    chk("step_fall", 32'(dif.fall),       32'h0);
    chk("step_any",  32'(dif.any_event),  32'h1);
    tick();
    chk("step_rise_end", 32'(dif.rise),      32'h0);
    chk("step_any_end",  32'(dif.any_event), 32'h0);
    chk("step_hold",     32'(dif.signal_out), 32'h1);

    // Glitch on ch1: 11 cycles high is rejected.
    dif.signal_in = 4'h3;
    tick(11);
    dif.signal_in = 4'h1;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= dif.rise | dif.fall;
    end
    chk("glitch_out",   32'(dif.signal_out), 32'h1);
    chk("glitch_pulse", 32'(seen),           32'h0);

    // 12 cycles high is accepted, then the return low produces a fall.
    dif.signal_in = 4'h3;
    tick(12);
    dif.signal_in = 4'h1;
    tick(2);
    chk("g12_out",  32'(dif.signal_out), 32'h3);
    chk("g12_rise", 32'(dif.rise),       32'h2);
    tick();
    chk("g12_rise_end", 32'(dif.rise), 32'h0);
    tick(10);
    chk("g12_fall_early", 32'(dif.fall),       32'h0);
    chk("g12_out_hold",   32'(dif.signal_out), 32'h3);
    tick();
    chk("g12_fall", 32'(dif.fall),       32'h2);
    chk("g12_back", 32'(dif.signal_out), 32'h1);

    // Bounce train on ch2, then settle high.
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      dif.signal_in = {1'b0, ~k[0], 2'b01};
      for (int j = 0; j < 3; j++) begin
        tick();
        seen |= dif.rise | dif.fall;
      end
    end
    dif.signal_in = 4'h5;
    for (int i = 0; i < 13; i++) begin
      tick();
      seen |= dif.rise | dif.fall;
    end
    chk("bounce_quiet", 32'(seen),           32'h0);
    chk("bounce_early", 32'(dif.signal_out), 32'h1);
    tick();
    chk("bounce_rise", 32'(dif.rise),       32'h4);
    chk("bounce_out",  32'(dif.signal_out), 32'h5);
    tick();
    chk("bounce_rise_end", 32'(dif.rise), 32'h0);

    // ch0 falls and ch3 rises together.
    dif.signal_in = 4'hC;
    tick(13);
    chk("simA_early", 32'(dif.signal_out), 32'h5);
    tick();
    chk("simA_out",  32'(dif.signal_out), 32'hC);
    chk("simA_rise", 32'(dif.rise),       32'h8);
    chk("simA_fall", 32'(dif.fall),       32'h1);
    tick(20);

    // ch0 rises and ch3 falls on the same edge.
    dif.signal_in = 4'h5;
    tick(14);
    chk("simB_out",  32'(dif.signal_out), 32'h5);
    chk("simB_rise", 32'(dif.rise),       32'h1);
    chk("simB_fall", 32'(dif.fall),       32'h8);
    chk("simB_any",  32'(dif.any_event),  32'h1);
    tick();
    chk("simB_any_end",  32'(dif.any_event), 32'h0);
    chk("simB_rise_end", 32'(dif.rise),      32'h0);
    chk("simB_fall_end", 32'(dif.fall),      32'h0);

    // Reset while ch1/ch3 counters sit at 7.
    dif.signal_in = 4'hF;
    tick(10);
    rst = 1'b1;
    tick();
    chk("mrst_out",  32'(dif.signal_out), 32'h0);
    chk("mrst_rise", 32'(dif.rise),       32'h0);
    chk("mrst_fall", 32'(dif.fall),       32'h0);
    chk("mrst_any",  32'(dif.any_event),  32'h0);
    rst = 1'b0;
    seen = '0;
    for (int i = 0; i < 13; i++) begin
      tick();
      seen |= dif.rise | dif.fall;
    end
    chk("mrst_quiet", 32'(seen),           32'h0);
    chk("mrst_early", 32'(dif.signal_out), 32'h0);
    tick();
    chk("mrst_out2", 32'(dif.signal_out), 32'hF);
    chk("mrst_rise2", 32'(dif.rise),      32'hF);
    chk("mrst_any2", 32'(dif.any_event),  32'h1);
    tick();
    chk("mrst_rise_end", 32'(dif.rise), 32'h0);

    // Saturation: long hold on ch0 gives a single rise.
    dif.signal_in = 4'h0;
    tick(20);
    chk("sat_pre", 32'(dif.signal_out), 32'h0);
    dif.signal_in = 4'h1;
    nrise0 = 0;
    nother = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (dif.rise[0]) nrise0++;
      if (dif.fall != 4'h0 || dif.rise[3:1] != 3'h0) nother++;
    end
    chk("sat_nrise", 32'(nrise0),          32'd1);
    chk("sat_other", 32'(nother),          32'd0);
    chk("sat_out",   32'(dif.signal_out), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel debouncer for mechanical switches and buttons. It is the next generation of the single-bit debouncer. Each channel gets an input synchroniser, a saturating stability counter, a programmable reset level and single-cycle rise/fall event pulses. It sits between board-level pushbuttons/switches and the control logic, so downstream FSMs consume clean levels and edge events without their own edge detectors.

## Interface
- CHANNELS, 4: number of independent input channels (≥1)
- DELAY, 10ms: required stability time before a new level is accepted
- CLOCK_PERIOD, 20ns: period of clk; COUNT = DELAY / CLOCK_PERIOD (integer, ≥1)
- SYNC_STAGES, 2: flip-flops in each input synchroniser (≥2)
- RESET_LEVEL, 1'b0: value loaded into synchroniser, history and output registers at reset (same for all channels)

Ports:
- clk  input  1  system clock; one clock domain
- rst  input  1  reset; synchronous, active-high
- signal_in  input  CHANNELS  raw asynchronous switch levels
- signal_out  output  CHANNELS  debounced levels
- rise  output  CHANNELS  one-cycle pulse when signal_out bit goes 0→1
- fall  output  CHANNELS  one-cycle pulse when signal_out bit goes 1→0
- any_event  output  1  OR-reduction of rise | fall, registered with them

## Operation
- Channels are fully independent; each has sync chain s, history p, counter cnt, output o.
- Synchroniser: signal_in[i] passes through SYNC_STAGES flops; the last stage is s.
- Every cycle, p <= s.
- Counter rules, in priority order:
  - s != p: cnt <= 0.
  - cnt == COUNT: cnt holds (saturates). If s != o: o <= s, and rise or fall pulses per direction.
  - Otherwise: cnt <= cnt + 1.
- Counter never wraps. It restarts only on a change of s or on reset.
- Acceptance rule: a synchronised level must be held for at least COUNT+2 consecutive cycles to reach signal_out. Shorter levels (bounces, glitches) are discarded.
- rise/fall are high for exactly one cycle and never both on one channel. Several channels may pulse in the same cycle.
- Reset, mid-count or otherwise:
  - all sync flops, p and o go to RESET_LEVEL
  - cnt goes to 0
  - rise, fall and any_event go to 0
  - no pulse is generated on reset entry or exit
- After reset, if signal_in equals RESET_LEVEL, no event occurs.
- Elaboration fails (fatal) if COUNT < 1, SYNC_STAGES < 2 or CHANNELS < 1.

## Timing
- Latency: raw change first sampled at edge R0 → signal_out and pulse valid after edge R(SYNC_STAGES+COUNT+1).
- rise/fall/any_event change on the same edge as signal_out.
- Counter width is $clog2(COUNT+1) bits. Sizing must not truncate for COUNT up to 2^24.
- All outputs are registered; there are no combinational paths from signal_in.

## Structure
- Package debounce_pkg holds:
  - function count_of(DELAY, CLOCK_PERIOD)
  - function cnt_width(count)
  - the parameter legality checks as a reusable macro or function
- Sub-module debounce_channel holds the synchroniser, counter and edge logic for one bit. The top generates CHANNELS instances and ORs the pulses into any_event.

## Test plan
Common parameters: CHANNELS=4, DELAY=100ns, CLOCK_PERIOD=10ns (COUNT=10), SYNC_STAGES=2, RESET_LEVEL=0.
- Clean step: ch0 0→1 held → signal_out[0]=1 and rise[0]=1 for one cycle, exactly 13 edges after first sampling. fall, other channels and any_event stay correct.
- Glitch rejection: ch1 high for 11 cycles then low → no change, no pulse. High for 12 cycles → signal_out[1] rises. After the 1→0 return is held 12 cycles, fall[1] pulses.
- Bounce train: ch2 toggles every 3 cycles for 60 cycles, then settles high → exactly one rise[2], 13 edges after the final settling edge.
- Simultaneous events: ch0 rises and ch3 falls (pre-set high) on the same edge → rise[0] and fall[3] in the same cycle, any_event=1 for one cycle only.
- Reset mid-count: assert rst at cnt=7 with signal_in=4'hF → next cycle all outputs 0. After release, the full 13-cycle latency applies again.
- Saturation: hold ch0 high 1000 cycles → signal_out[0] stays 1, exactly one rise[0], no further pulses.
